// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/issue stage: opcodes, instruction
// field positions and FSM state encoding.
package alu_pkg;

  // ALU opcodes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  // Instruction field bit positions (16-bit instruction word)
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 14;
  localparam int RD_HI   = 13;
  localparam int RD_LO   = 11;
  localparam int RS1_HI  = 10;
  localparam int RS1_LO  = 8;
  localparam int IMM_SEL = 7;
  localparam int IMM_LO  = 0;
  localparam int RS2_HI  = 2;
  localparam int RS2_LO  = 0;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Shift opcodes have op[1] set; their B operand is limited to 0..31.
  function automatic logic is_shift(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two combinational read ports, one write port,
// synchronous reset to zero. With ZERO_REG_EN defined, register 0 is
// hardwired to zero and writes to it are discarded.
module alu_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  // Next register contents: apply the single write, keep r0 at zero if hardwired
  always_comb begin
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[waddr] = wdata;
`ifdef ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  // Register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue/operand stage in front of a 32-bit add/sub/shl/shr ALU.
// Accepts 16-bit instructions over valid/ready, reads operands from an
// internal 8-entry register file, registers the ALU inputs, writes the ALU
// result back one cycle later and offers it downstream over valid/ready.
// Optional build macro: ZERO_REG_EN (register 0 hardwired to zero).
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_inputA,
  output logic [DATA_W-1:0] alu_inputB,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_rd
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        rd_q, rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [2:0]        res_rd_q, res_rd_d;
  logic              res_valid_q, res_valid_d;

  logic [1:0]        f_op;
  logic [2:0]        f_rd, f_rs1, f_rs2;
  logic              f_imm_sel;
  logic [DATA_W-1:0] f_imm;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic [DATA_W-1:0] opb_val;
  logic              accept;
  logic              wb_en;

  // Instruction field extraction
  assign f_op      = instr[OP_HI:OP_LO];
  assign f_rd      = instr[RD_HI:RD_LO];
  assign f_rs1     = instr[RS1_HI:RS1_LO];
  assign f_rs2     = instr[RS2_HI:RS2_LO];
  assign f_imm_sel = instr[IMM_SEL];
  assign f_imm     = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_LO+IMM_W-1:IMM_LO]};

  assign instr_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && res_ready);
  assign accept      = instr_valid && instr_ready;
  assign wb_en       = (state_q == ST_EXEC);

  alu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (f_rs1),
    .rdata_a (rs1_val),
    .raddr_b (f_rs2),
    .rdata_b (rs2_val),
    .we      (wb_en),
    .waddr   (rd_q),
    .wdata   (alu_result)
  );

  // Operand B selection; shifts keep only the low 5 bits of the amount
  always_comb begin
    opb_val = f_imm_sel ? f_imm : rs2_val;
    if (is_shift(f_op)) opb_val[DATA_W-1:5] = '0;
  end

  // FSM next-state, operand latching and result capture
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rd_d        = rd_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_data_d  = alu_result;
        res_rd_d    = rd_q;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d  = rs1_val;
      b_d  = opb_val;
      op_d = f_op;
      rd_d = f_rd;
    end
  end

  // State and output registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_inputA = a_q;
  assign alu_inputB = b_q;
  assign alu_opcode = op_q;
  assign res_data   = res_data_q;
  assign res_rd     = res_rd_q;
  assign res_valid  = res_valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: a transaction-level model of the stage
// checked against the DUT every cycle, plus directed literal expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] alu_inputA, alu_inputB, alu_result;
  logic [1:0]  alu_opcode;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_W(32), .IMM_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_inputA  (alu_inputA),
    .alu_inputB  (alu_inputB),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd)
  );

  // Behavioural ALU driven by the DUT's registered inputs
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_result = alu_inputA + alu_inputB;
      2'b01:   alu_result = alu_inputA - alu_inputB;
      2'b10:   alu_result = alu_inputA << alu_inputB;
      default: alu_result = alu_inputA >> alu_inputB;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic isel,
                                     input logic [6:0] imm);
    return {op, rd, rs1, isel, imm};
  endfunction

  function automatic logic [31:0] calc(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // ---------------- transaction model ----------------
  logic [31:0] m_regs [8];
  logic [31:0] m_a, m_b, m_data, m_wb_val;
  logic [1:0]  m_op;
  logic [2:0]  m_rd, m_wb_rd;
  logic        m_valid, m_resp, m_wb_pending;
  logic        started = 1'b0;

  function automatic logic model_ready();
    return !m_wb_pending && (!m_resp || res_ready);
  endfunction

  always @(posedge clk) begin
    logic        acc;
    logic [31:0] opb;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_rd = '0;
      m_valid = 0; m_resp = 0; m_wb_pending = 0; m_wb_val = '0; m_wb_rd = '0;
      started = 1'b1;
    end else if (started) begin
      acc = instr_valid && model_ready();
      if (m_wb_pending) begin
`ifdef ZERO_REG_EN
        if (m_wb_rd != 3'd0) m_regs[m_wb_rd] = m_wb_val;
`else
        m_regs[m_wb_rd] = m_wb_val;
`endif
        m_data = m_wb_val; m_rd = m_wb_rd; m_valid = 1; m_resp = 1; m_wb_pending = 0;
      end else if (m_resp && res_ready) begin
        m_valid = 0; m_resp = 0;
      end
      if (acc) begin
        opb = instr[7] ? {25'd0, instr[6:0]} : m_regs[instr[2:0]];
        if (instr[15]) opb = opb & 32'h1F;
        m_a = m_regs[instr[10:8]];
        m_b = opb;
        m_op = instr[15:14];
        m_wb_rd = instr[13:11];
        m_wb_val = calc(m_op, m_a, m_b);
        m_wb_pending = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("cmp_instr_ready", {31'd0, instr_ready}, {31'd0, model_ready()});
      chk("cmp_res_valid", {31'd0, res_valid}, {31'd0, m_valid});
      chk("cmp_alu_inputA", alu_inputA, m_a);
      chk("cmp_alu_inputB", alu_inputB, m_b);
      chk("cmp_alu_opcode", {30'd0, alu_opcode}, {30'd0, m_op});
      if (m_valid) begin
        chk("cmp_res_data", res_data, m_data);
        chk("cmp_res_rd", {29'd0, res_rd}, {29'd0, m_rd});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Present an instruction until accepted; returns #1 after the accept edge.
  task automatic issue(input logic [15:0] w);
    logic ok;
    int   cnt;
    instr = w;
    instr_valid = 1'b1;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 20) begin
      @(negedge clk);
      ok = instr_ready;
      @(posedge clk);
      cnt++;
    end
    #1 instr_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: instruction 0x%04h not accepted within 20 cycles", w);
    end
  endtask

  // After issue(): check ALU inputs in EXEC, then the presented result.
  task automatic expect_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] data, input logic [2:0] rd);
    @(negedge clk);
    chk({name, "_A"}, alu_inputA, a);
    chk({name, "_B"}, alu_inputB, b);
    chk({name, "_op"}, {30'd0, alu_opcode}, {30'd0, op});
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({name, "_data"}, res_data, data);
    chk({name, "_rd"}, {29'd0, res_rd}, {29'd0, rd});
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_cnt;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_alu_inputA", alu_inputA, 32'd0);
    @(posedge clk); #1;

    // ADDI r1 = r0 + 5
    issue(mk(2'b00, 3'd1, 3'd0, 1'b1, 7'd5));
    expect_op("addi", 32'd0, 32'd5, 2'b00, 32'd5, 3'd1);

    // SUB r3 = r0 - r1 (negative wrap), then read r3 back
    issue(mk(2'b01, 3'd3, 3'd0, 1'b0, 7'd1));
    expect_op("sub", 32'd0, 32'd5, 2'b01, 32'hFFFF_FFFB, 3'd3);
    issue(mk(2'b00, 3'd5, 3'd3, 1'b1, 7'd0));
    expect_op("read_r3", 32'hFFFF_FFFB, 32'd0, 2'b00, 32'hFFFF_FFFB, 3'd5);

    // SHL r4 = r1 << 3 ; r2 = 0x25 ; SHR r6 = r4 >> r2 (amount masked to 5)
    issue(mk(2'b10, 3'd4, 3'd1, 1'b1, 7'd3));
    expect_op("shl", 32'd5, 32'd3, 2'b10, 32'd40, 3'd4);
    issue(mk(2'b00, 3'd2, 3'd0, 1'b1, 7'h25));
    expect_op("li_r2", 32'd0, 32'h25, 2'b00, 32'h25, 3'd2);
    issue(mk(2'b11, 3'd6, 3'd4, 1'b0, 7'd2));
    expect_op("shr", 32'd40, 32'd5, 2'b11, 32'd1, 3'd6);

    // Backpressure: result held while res_ready is low
    res_ready = 1'b0;
    issue(mk(2'b00, 3'd7, 3'd0, 1'b1, 7'd9));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", res_data, 32'd9);
      chk("bp_rd", {29'd0, res_rd}, 32'd7);
      chk("bp_ready", {31'd0, instr_ready}, 32'd0);
    end
    @(posedge clk); #1;
    // Release with a waiting instruction: back-to-back r7 += 1
    instr = mk(2'b00, 3'd7, 3'd7, 1'b1, 7'd1);
    instr_valid = 1'b1;
    res_ready = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instr_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", acc_cnt, 32'd4);
    repeat (3) @(posedge clk); #1;
    issue(mk(2'b00, 3'd5, 3'd7, 1'b1, 7'd0));
    expect_op("read_r7", 32'd13, 32'd0, 2'b00, 32'd13, 3'd5);

    // Reset during EXEC aborts the writeback
    issue(mk(2'b00, 3'd2, 3'd0, 1'b1, 7'd9));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstx_valid", {31'd0, res_valid}, 32'd0);
    chk("rstx_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    issue(mk(2'b00, 3'd1, 3'd2, 1'b1, 7'd0));
    expect_op("rstx_r2", 32'd0, 32'd0, 2'b00, 32'd0, 3'd1);

    // Register 0 behaviour
    issue(mk(2'b00, 3'd0, 3'd0, 1'b1, 7'd7));
    expect_op("wr_r0", 32'd0, 32'd7, 2'b00, 32'd7, 3'd0);
    issue(mk(2'b00, 3'd1, 3'd0, 1'b1, 7'd0));
`ifdef ZERO_REG_EN
    expect_op("rd_r0", 32'd0, 32'd0, 2'b00, 32'd0, 3'd1);
`else
    expect_op("rd_r0", 32'd7, 32'd0, 2'b00, 32'd7, 3'd1);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
